// File: rtl/dcache_refill_ctrl.sv
// Memory-side controller for a direct-mapped, write-through (no-allocate) data cache.
// Defining DCACHE_STATS_EN adds saturating counters: stat_loads, stat_load_miss, stat_stores.
module dcache_refill_ctrl #(
  parameter int INDEX_WIDTH = 3,
  parameter int TAG_WIDTH   = 27,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lk_valid,
  input  logic                   lk_we,
  input  logic                   lk_hit,
  input  logic [31:0]            lk_addr,
  input  logic [31:0]            lk_wdata,
  output logic                   stall,
  output logic                   fill_en,
  output logic [INDEX_WIDTH-1:0] fill_index,
  output logic [TAG_WIDTH-1:0]   fill_tag,
  output logic [31:0]            fill_data,
  output logic                   resp_valid,
  output logic [31:0]            resp_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ready,
  input  logic [31:0]            mem_rdata,
`ifdef DCACHE_STATS_EN
  output logic [31:0]            stat_loads,
  output logic [31:0]            stat_load_miss,
  output logic [31:0]            stat_stores,
`endif
  output logic                   err
);

  localparam int CNT_WIDTH = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, FILL} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [31:0]            rdata_q;
  logic                   in_req;
  logic                   timeout;
  logic                   accept;
  logic [INDEX_WIDTH-1:0] lk_index, req_index;
  logic [TAG_WIDTH-1:0]   lk_tag, req_tag;
  logic                   unused_addr_bits;

  assign lk_index         = lk_addr[INDEX_WIDTH+1:2];
  assign lk_tag           = lk_addr[31:INDEX_WIDTH+2];
  assign req_index        = mem_addr[INDEX_WIDTH+1:2];
  assign req_tag          = mem_addr[31:INDEX_WIDTH+2];
  assign unused_addr_bits = ^lk_addr[1:0];

  assign in_req  = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign timeout = in_req && !mem_ready && (cnt_q == CNT_LAST);
  assign accept  = (state_q == IDLE) && lk_valid && (lk_we || !lk_hit);

  // Strobes are gated by rst so an aborted transaction never leaks a fill or response.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    stall      = 1'b0;
    fill_en    = 1'b0;
    fill_index = '0;
    fill_tag   = '0;
    fill_data  = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            stall   = 1'b1;
            state_d = lk_we ? WR_REQ : RD_REQ;
            if (lk_we && lk_hit) begin
              fill_en    = 1'b1;
              fill_index = lk_index;
              fill_tag   = lk_tag;
              fill_data  = lk_wdata;
            end
          end
        end
        RD_REQ: begin
          stall = 1'b1;
          if (mem_ready) begin
            state_d = FILL;
          end else if (timeout) begin
            resp_valid = 1'b1;
            state_d    = IDLE;
          end
        end
        WR_REQ: begin
          stall = 1'b1;
          if (mem_ready || timeout) state_d = IDLE;
        end
        FILL: begin
          stall      = 1'b1;
          fill_en    = 1'b1;
          fill_index = req_index;
          fill_tag   = req_tag;
          fill_data  = rdata_q;
          resp_valid = 1'b1;
          resp_data  = rdata_q;
          state_d    = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mem_req  <= 1'b1;
        mem_we   <= lk_we;
        mem_addr <= {lk_addr[31:2], 2'b00};
        cnt_q    <= '0;
        if (lk_we) mem_wdata <= lk_wdata;
      end else if (in_req) begin
        cnt_q <= cnt_q + 1'b1;
        // mem_ready takes priority over a timeout landing in the same cycle.
        if (mem_ready) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          if (state_q == RD_REQ) rdata_q <= mem_rdata;
        end else if (timeout) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          err     <= 1'b1;
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic take_load, take_store;
  assign take_load  = (state_q == IDLE) && lk_valid && !lk_we;
  assign take_store = (state_q == IDLE) && lk_valid && lk_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads     <= '0;
      stat_load_miss <= '0;
      stat_stores    <= '0;
    end else begin
      if (take_load && (stat_loads != '1))                 stat_loads     <= stat_loads + 32'd1;
      if (take_load && !lk_hit && (stat_load_miss != '1))  stat_load_miss <= stat_load_miss + 32'd1;
      if (take_store && (stat_stores != '1))               stat_stores    <= stat_stores + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed self-checking bench for dcache_refill_ctrl (MEM_TIMEOUT=4 so timeouts are reachable).
module tb_dcache_refill_ctrl;

  localparam int IW = 3;
  localparam int TW = 27;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          lk_valid, lk_we, lk_hit;
  logic [31:0]   lk_addr, lk_wdata;
  logic          stall, fill_en, resp_valid, mem_req, mem_we, mem_ready, err;
  logic [IW-1:0] fill_index;
  logic [TW-1:0] fill_tag;
  logic [31:0]   fill_data, resp_data, mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]   stat_loads, stat_load_miss, stat_stores;
`endif

  dcache_refill_ctrl #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_we(lk_we), .lk_hit(lk_hit), .lk_addr(lk_addr), .lk_wdata(lk_wdata),
    .stall(stall), .fill_en(fill_en), .fill_index(fill_index), .fill_tag(fill_tag), .fill_data(fill_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
`ifdef DCACHE_STATS_EN
    .stat_loads(stat_loads), .stat_load_miss(stat_load_miss), .stat_stores(stat_stores),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_loads = 0, exp_miss = 0, exp_stores = 0;

  // Observations gathered over one access, from accept until the first non-stalled cycle.
  int            obs_stall, obs_fill_n, obs_fill_cyc, obs_resp_n, obs_resp_cyc, obs_req_n, obs_req_rises;
  logic [IW-1:0] obs_fill_idx;
  logic [TW-1:0] obs_fill_tag;
  logic [31:0]   obs_fill_data, obs_resp_data, obs_mem_addr, obs_mem_wdata;
  logic          obs_mem_we, obs_unstable, obs_exit_req;

  // Present one access, hold it while stall is high, model memory answering on req cycle ready_at
  // (0 = never). Returns at negedge+1 of the first cycle with stall low and lk_valid dropped.
  task automatic run_access(input logic we, input logic hit, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int ready_at);
    int          cyc = 0;
    int          req_n = 0;
    logic        prev_req = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    obs_stall = 0; obs_fill_n = 0; obs_fill_cyc = -1; obs_resp_n = 0; obs_resp_cyc = -1;
    obs_req_n = 0; obs_req_rises = 0; obs_fill_idx = '0; obs_fill_tag = '0; obs_fill_data = '0;
    obs_resp_data = '0; obs_mem_addr = '0; obs_mem_wdata = '0; obs_mem_we = 1'b0; obs_unstable = 1'b0;
    if (we) exp_stores++;
    else begin
      exp_loads++;
      if (!hit) exp_miss++;
    end
    lk_valid = 1'b1; lk_we = we; lk_hit = hit; lk_addr = addr; lk_wdata = wdata;
    while (1) begin
      if (mem_req) req_n++;
      mem_ready = mem_req && (req_n == ready_at);
      mem_rdata = mem_ready ? rdata : 32'hA5A5_A5A5;
      #1;
      if (stall) obs_stall++;
      if (fill_en) begin
        obs_fill_n++; obs_fill_cyc = cyc;
        obs_fill_idx = fill_index; obs_fill_tag = fill_tag; obs_fill_data = fill_data;
      end
      if (resp_valid) begin
        obs_resp_n++; obs_resp_cyc = cyc; obs_resp_data = resp_data;
      end
      if (mem_req) begin
        obs_req_n++;
        if (!prev_req) obs_req_rises++;
        else if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata)
          obs_unstable = 1'b1;
        obs_mem_addr = mem_addr; obs_mem_we = mem_we; obs_mem_wdata = mem_wdata;
      end
      prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
      @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      cyc++;
      lk_valid = 1'b0;
      #1;
      if (!stall || cyc >= 40) break;
      lk_valid = 1'b1;
    end
    obs_exit_req = mem_req;
  endtask

  task automatic test_reset();
    rst = 1'b1; lk_valid = 1'b0; lk_we = 1'b0; lk_hit = 1'b0; lk_addr = '0; lk_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if ({stall, fill_en, resp_valid} !== 3'b000) begin miscompares++;
      $display("FAIL reset_strobes: got %b expected 000", {stall, fill_en, resp_valid}); end
    vectors++; if ({mem_req, mem_we, err} !== 3'b000) begin miscompares++;
      $display("FAIL reset_mem_ctl: got %b expected 000", {mem_req, mem_we, err}); end
    vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin miscompares++;
      $display("FAIL reset_mem_data: got addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata); end
    vectors++; if (fill_index !== '0 || fill_tag !== '0 || fill_data !== 32'h0 || resp_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_fill_resp: got idx=%h tag=%h data=%h resp=%h expected all 0",
               fill_index, fill_tag, fill_data, resp_data); end
`ifdef DCACHE_STATS_EN
    vectors++; if (stat_loads !== 0 || stat_load_miss !== 0 || stat_stores !== 0) begin miscompares++;
      $display("FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", stat_loads, stat_load_miss, stat_stores); end
`endif
  endtask

  task automatic test_load_miss();
    run_access(1'b0, 1'b0, 32'h0000_0014, 32'h0, 32'hDEAD_BEEF, 3);
    vectors++; if (obs_stall !== 5) begin miscompares++;
      $display("FAIL load_miss_stall: got %0d expected 5", obs_stall); end
    vectors++; if (obs_mem_addr !== 32'h14 || obs_mem_we !== 1'b0 || obs_req_n !== 3) begin miscompares++;
      $display("FAIL load_miss_req: got addr=%h we=%b cycles=%0d expected 14/0/3",
               obs_mem_addr, obs_mem_we, obs_req_n); end
    vectors++; if (obs_fill_n !== 1 || obs_fill_cyc !== 4 || obs_fill_idx !== 3'd5 || obs_fill_tag !== '0
                   || obs_fill_data !== 32'hDEAD_BEEF) begin miscompares++;
      $display("FAIL load_miss_fill: got n=%0d cyc=%0d idx=%0d tag=%h data=%h expected 1/4/5/0/deadbeef",
               obs_fill_n, obs_fill_cyc, obs_fill_idx, obs_fill_tag, obs_fill_data); end
    vectors++; if (obs_resp_n !== 1 || obs_resp_cyc !== 4 || obs_resp_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL load_miss_resp: got n=%0d cyc=%0d data=%h expected 1/4/deadbeef",
               obs_resp_n, obs_resp_cyc, obs_resp_data); end
    vectors++; if (obs_unstable !== 1'b0 || obs_exit_req !== 1'b0 || err !== 1'b0) begin miscompares++;
      $display("FAIL load_miss_req_shape: got unstable=%b exit_req=%b err=%b expected 0/0/0",
               obs_unstable, obs_exit_req, err); end
    // Minimum latency: ready on the first request cycle.
    run_access(1'b0, 1'b0, 32'h0000_001C, 32'h0, 32'h0BAD_F00D, 1);
    vectors++; if (obs_stall !== 3 || obs_resp_cyc !== 2 || obs_fill_idx !== 3'd7
                   || obs_resp_data !== 32'h0BAD_F00D) begin miscompares++;
      $display("FAIL load_miss_min: got stall=%0d resp_cyc=%0d idx=%0d data=%h expected 3/2/7/0badf00d",
               obs_stall, obs_resp_cyc, obs_fill_idx, obs_resp_data); end
  endtask

  task automatic test_store_hit();
    run_access(1'b1, 1'b1, 32'h0000_1008, 32'h1234_5678, 32'h0, 2);
    vectors++; if (obs_fill_n !== 1 || obs_fill_cyc !== 0 || obs_fill_idx !== 3'd2 || obs_fill_tag !== 27'h80
                   || obs_fill_data !== 32'h1234_5678) begin miscompares++;
      $display("FAIL store_hit_fill: got n=%0d cyc=%0d idx=%0d tag=%h data=%h expected 1/0/2/80/12345678",
               obs_fill_n, obs_fill_cyc, obs_fill_idx, obs_fill_tag, obs_fill_data); end
    vectors++; if (obs_mem_addr !== 32'h1008 || obs_mem_we !== 1'b1 || obs_mem_wdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL store_hit_mem: got addr=%h we=%b wdata=%h expected 1008/1/12345678",
               obs_mem_addr, obs_mem_we, obs_mem_wdata); end
    vectors++; if (obs_stall !== 3 || obs_resp_n !== 0 || obs_unstable !== 1'b0) begin miscompares++;
      $display("FAIL store_hit_timing: got stall=%0d resp=%0d unstable=%b expected 3/0/0",
               obs_stall, obs_resp_n, obs_unstable); end
  endtask

  task automatic test_store_miss();
    run_access(1'b1, 1'b0, 32'h0000_1008, 32'h1234_5678, 32'h0, 1);
    vectors++; if (obs_fill_n !== 0 || obs_resp_n !== 0) begin miscompares++;
      $display("FAIL store_miss_nofill: got fill=%0d resp=%0d expected 0/0", obs_fill_n, obs_resp_n); end
    vectors++; if (obs_stall !== 2 || obs_mem_we !== 1'b1 || obs_mem_addr !== 32'h1008
                   || obs_mem_wdata !== 32'h1234_5678) begin miscompares++;
      $display("FAIL store_miss_mem: got stall=%0d we=%b addr=%h wdata=%h expected 2/1/1008/12345678",
               obs_stall, obs_mem_we, obs_mem_addr, obs_mem_wdata); end
  endtask

  task automatic test_load_hit();
    run_access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 1);
    vectors++; if (obs_stall !== 0 || obs_fill_n !== 0 || obs_resp_n !== 0 || obs_req_n !== 0) begin
      miscompares++;
      $display("FAIL load_hit_idle: got stall=%0d fill=%0d resp=%0d req=%0d expected 0/0/0/0",
               obs_stall, obs_fill_n, obs_resp_n, obs_req_n); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b0, 32'h0000_0014, 32'h0, 32'h1111_1111, 2);
    vectors++; if (obs_exit_req !== 1'b0 || obs_req_rises !== 1 || obs_resp_data !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL b2b_first: got exit_req=%b rises=%0d data=%h expected 0/1/11111111",
               obs_exit_req, obs_req_rises, obs_resp_data); end
    run_access(1'b0, 1'b0, 32'h0000_0034, 32'h0, 32'h2222_2222, 1);
    vectors++; if (obs_fill_n !== 1 || obs_fill_idx !== 3'd5 || obs_fill_tag !== 27'h1
                   || obs_fill_data !== 32'h2222_2222) begin miscompares++;
      $display("FAIL b2b_second_fill: got n=%0d idx=%0d tag=%h data=%h expected 1/5/1/22222222",
               obs_fill_n, obs_fill_idx, obs_fill_tag, obs_fill_data); end
    vectors++; if (obs_stall !== 3 || obs_req_rises !== 1 || obs_mem_addr !== 32'h34) begin miscompares++;
      $display("FAIL b2b_second_req: got stall=%0d rises=%0d addr=%h expected 3/1/34",
               obs_stall, obs_req_rises, obs_mem_addr); end
  endtask

  task automatic test_ready_beats_timeout();
    run_access(1'b0, 1'b0, 32'h0000_000C, 32'h0, 32'hCAFE_0004, TO);
    vectors++; if (obs_stall !== 6 || obs_fill_n !== 1 || obs_fill_idx !== 3'd3
                   || obs_resp_data !== 32'hCAFE_0004 || err !== 1'b0) begin miscompares++;
      $display("FAIL ready_vs_timeout: got stall=%0d fill=%0d idx=%0d data=%h err=%b expected 6/1/3/cafe0004/0",
               obs_stall, obs_fill_n, obs_fill_idx, obs_resp_data, err); end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'hFFFF_FFFF, 0);
    vectors++; if (obs_req_n !== TO || obs_stall !== 5 || obs_exit_req !== 1'b0) begin miscompares++;
      $display("FAIL timeout_load_req: got req=%0d stall=%0d exit_req=%b expected 4/5/0",
               obs_req_n, obs_stall, obs_exit_req); end
    vectors++; if (obs_resp_n !== 1 || obs_resp_cyc !== 4 || obs_resp_data !== 32'h0 || obs_fill_n !== 0) begin
      miscompares++;
      $display("FAIL timeout_load_resp: got n=%0d cyc=%0d data=%h fill=%0d expected 1/4/0/0",
               obs_resp_n, obs_resp_cyc, obs_resp_data, obs_fill_n); end
    vectors++; if (err !== 1'b1) begin miscompares++;
      $display("FAIL timeout_err_set: got %b expected 1", err); end
    run_access(1'b1, 1'b0, 32'h0000_0044, 32'h5555_AAAA, 32'h0, 1);
    vectors++; if (err !== 1'b1 || obs_stall !== 2 || obs_mem_wdata !== 32'h5555_AAAA) begin miscompares++;
      $display("FAIL timeout_err_sticky: got err=%b stall=%0d wdata=%h expected 1/2/5555aaaa",
               err, obs_stall, obs_mem_wdata); end
    run_access(1'b1, 1'b0, 32'h0000_0048, 32'h0F0F_0F0F, 32'h0, 0);
    vectors++; if (obs_stall !== 5 || obs_resp_n !== 0 || obs_fill_n !== 0 || obs_exit_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_store: got stall=%0d resp=%0d fill=%0d exit_req=%b expected 5/0/0/0",
               obs_stall, obs_resp_n, obs_fill_n, obs_exit_req); end
  endtask

  task automatic test_reset_mid();
    lk_valid = 1'b1; lk_we = 1'b0; lk_hit = 1'b0; lk_addr = 32'h0000_0058; lk_wdata = '0;
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++;
      $display("FAIL rst_mid_accept: got stall=%b expected 1", stall); end
    @(posedge clk);
    @(negedge clk);
    lk_valid = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h58) begin miscompares++;
      $display("FAIL rst_mid_in_req: got req=%b addr=%h expected 1/58", mem_req, mem_addr); end
`ifdef DCACHE_STATS_EN
    vectors++; if (stat_loads !== exp_loads + 1 || stat_load_miss !== exp_miss + 1 || stat_stores !== exp_stores)
    begin miscompares++;
      $display("FAIL stats_counts: got %0d/%0d/%0d expected %0d/%0d/%0d", stat_loads, stat_load_miss,
               stat_stores, exp_loads + 1, exp_miss + 1, exp_stores); end
`endif
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    vectors++; if (fill_en !== 1'b0 || resp_valid !== 1'b0) begin miscompares++;
      $display("FAIL rst_mid_no_strobe: got fill=%b resp=%b expected 0/0", fill_en, resp_valid); end
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++; if ({mem_req, mem_we, err, stall} !== 4'b0000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got req/we/err/stall=%b addr=%h wdata=%h expected 0000/0/0",
               {mem_req, mem_we, err, stall}, mem_addr, mem_wdata); end
`ifdef DCACHE_STATS_EN
    vectors++; if (stat_loads !== 0 || stat_load_miss !== 0 || stat_stores !== 0) begin miscompares++;
      $display("FAIL rst_mid_stats: got %0d/%0d/%0d expected 0/0/0", stat_loads, stat_load_miss, stat_stores); end
`endif
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    vectors++; if ({fill_en, resp_valid, stall, mem_req} !== 4'b0000) begin miscompares++;
      $display("FAIL rst_mid_after: got fill/resp/stall/req=%b expected 0000",
               {fill_en, resp_valid, stall, mem_req}); end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store_hit();
    test_store_miss();
    test_load_hit();
    test_back_to_back();
    test_ready_beats_timeout();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
Memory-side controller for the pipeline's direct-mapped data cache. It owns the interface to main memory and services lookup-side misses, fills the tag/data array, and handles stores. Stores are write-through with write-update on hit and no-allocate on miss. It sits between the MEM-stage cache lookup and the data memory and stalls the pipeline while a transaction is outstanding.

Parameters:
INDEX_WIDTH, 3, set index bits; the cache has 2**INDEX_WIDTH sets, one 32-bit word per line
TAG_WIDTH, 27, tag bits; equal to 32-2-INDEX_WIDTH
MEM_TIMEOUT, 255, maximum cycles to wait for mem_ready before flagging an error

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
lk_valid  in  1  lookup side presents a MEM-stage access this cycle
lk_we  in  1  access is a store
lk_hit  in  1  lookup-side tag/valid match for lk_addr
lk_addr  in  32  byte address, word aligned
lk_wdata  in  32  store data
stall  out  1  freeze pipeline; high while not IDLE or while a new miss/store is being accepted
fill_en  out  1  one-cycle strobe: write the fill_* fields into the cache array
fill_index  out  INDEX_WIDTH  set to write
fill_tag  out  TAG_WIDTH  tag to write; the valid bit is set by the array
fill_data  out  32  line data
resp_valid  out  1  one-cycle strobe: load data returned to the pipeline
resp_data  out  32  load data, valid with resp_valid
mem_req  out  1  main-memory request, held until mem_ready
mem_we  out  1  request is a write
mem_addr  out  32  word-aligned address
mem_wdata  out  32  write data
mem_ready  in  1  memory accepts or completes the request this cycle
mem_rdata  in  32  read data, valid when mem_ready is high and mem_we is low
err  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- Reset: state=IDLE. stall, fill_en, resp_valid, mem_req, mem_we, err all 0. mem_addr, mem_wdata, fill_*, resp_data all 0.
- Address split: index=lk_addr[INDEX_WIDTH+1:2], tag=lk_addr[31:INDEX_WIDTH+2]. Bits [1:0] are ignored.
- IDLE:
  - Load hit (lk_valid & ~lk_we & lk_hit): no action; the lookup side serves the load.
  - Load miss (lk_valid & ~lk_we & ~lk_hit): latch addr; go to RD_REQ. stall is asserted combinationally in the same cycle.
  - Store (lk_valid & lk_we): latch addr and wdata; go to WR_REQ; stall is asserted combinationally.
    - If lk_hit, also pulse fill_en in that cycle with the latched index/tag/wdata (write-update).
- RD_REQ: mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ready: capture mem_rdata and go to FILL.
- FILL, one cycle:
  - fill_en=1 with index, tag and the captured data.
  - resp_valid=1 with resp_data equal to the captured data.
  - Go to IDLE. stall drops in the next cycle.
- WR_REQ: mem_req=1, mem_we=1, mem_addr and mem_wdata latched.
  - On mem_ready: go to IDLE. No fill on a store miss.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stable while mem_req is high. mem_req deasserts in the cycle after mem_ready.
- Latency, with ready-in-N cycles after mem_req rises:
  - Load miss: stall for N+2 cycles, resp_valid in the last stalled cycle.
  - Store: stall for N+1 cycles.
  - Minimum case is mem_ready on the first req cycle.
- lk_valid is ignored outside IDLE. The pipeline holds the same access stable while stall is high, and the controller must not re-trigger on it.
- Timeout: a counter runs in RD_REQ and WR_REQ. When it reaches MEM_TIMEOUT:
  - err=1, mem_req=0, go to IDLE.
  - A load in that case gets resp_valid with resp_data=0 and no fill.
- Same-cycle mem_ready and timeout: mem_ready wins.
- rst mid-transaction: abort immediately; mem_req=0 next cycle; no fill_en or resp_valid is emitted.

Optional Feature:
Macro: DCACHE_STATS_EN
- Defined: the block adds three outputs, each a 32-bit saturating counter cleared by rst and incremented once per event.
  - stat_loads: counts accepted loads.
  - stat_load_miss: counts load misses.
  - stat_stores: counts stores.
- Not defined: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
1. Load miss: lk_addr=0x0000_0014, lk_hit=0, mem_ready 3 cycles after req, mem_rdata=0xDEAD_BEEF -> mem_addr=0x14, fill_en with index=5, tag=0, data=0xDEADBEEF, resp_valid with 0xDEADBEEF, stall high for exactly 5 cycles.
2. Store hit: lk_addr=0x0000_1008, wdata=0x1234_5678, lk_hit=1 -> fill_en in the accept cycle with index=2, tag=0x80, data=0x12345678; mem write to 0x1008 with 0x12345678; no resp_valid.
3. Store miss: the same access with lk_hit=0 -> memory write only; fill_en never asserted.
4. Back-to-back: a load miss followed the cycle after stall drops by a load miss to 0x34 -> two independent RD_REQ sequences; the second fill has index=5, tag=1, and mem_req shows no glitch between them.
5. Timeout with MEM_TIMEOUT=4 and mem_ready held low on a load -> err=1 after 4 req cycles, resp_valid with data 0, no fill, IDLE; err stays high through later traffic until rst.
6. Reset asserted in RD_REQ -> mem_req=0 on the next edge and all outputs return to their reset values; with DCACHE_STATS_EN, all counters read 0.
